// File: rtl/hsv_core_pkg.sv
// Shared types for the hsv_core commit path: commit records, tokens and
// the commit-stage state encoding.
package hsv_core_pkg;

    localparam int TOKEN_W = 4;

    typedef logic [31:0]        word;
    typedef logic [4:0]         reg_addr;
    typedef logic [31:0]        reg_mask;
    typedef logic [TOKEN_W-1:0] insn_token;

    localparam insn_token TOKEN_INC = 4'd1;

    typedef struct packed {
        insn_token token;
        reg_addr   rd_addr;
    } commit_common_t;

    typedef struct packed {
        commit_common_t common;
        word            result;
        word            next_pc;
        reg_mask        rd_mask;
        logic           writeback;
        logic           jump;
        logic           trap;
        logic [4:0]     trap_cause;
        word            trap_value;
    } commit_data_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } commit_state_t;

endpackage

// File: rtl/hsv_core_commit_select.sv
// Token match, accept and one-hot OR selection across the execution
// channels, with detection of more than one simultaneous accept.
module hsv_core_commit_select
    import hsv_core_pkg::*;
#(
    parameter int NUM_PORTS = 5
) (
    input  commit_data_t           port_data_i [NUM_PORTS],
    input  logic [NUM_PORTS-1:0]   port_valid_i,
    input  insn_token              token_i,
    input  logic                   enable_i,
    output logic [NUM_PORTS-1:0]   ready_o,
    output logic [NUM_PORTS-1:0]   accept_o,
    output commit_data_t           used_o,
    output logic                   dup_o
);

    localparam logic [NUM_PORTS-1:0] ACC_ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    // Match each channel against the program-order token and OR accepted records.
    always_comb begin
        ready_o  = '0;
        accept_o = '0;
        used_o   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            ready_o[i]  = enable_i & (port_data_i[i].common.token == token_i);
            accept_o[i] = ready_o[i] & port_valid_i[i];
            if (accept_o[i]) begin
                used_o = used_o | port_data_i[i];
            end else begin
                used_o = used_o;
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more are set.
    assign dup_o = |(accept_o & (accept_o - ACC_ONE));

endmodule

// File: rtl/hsv_core_commit_multi.sv
// In-order commit stage: retires one matching record per cycle, drives
// writeback and trap/flush controls, and sequences drain/flush.
module hsv_core_commit_multi
    import hsv_core_pkg::*;
#(
    parameter int  NUM_PORTS = 5,
    parameter word RESET_PC  = 32'h0000_0000,
    parameter int  RETIRE_W  = 64
) (
    input  logic                  clk_core,
    input  logic                  rst_core_n,
    input  commit_data_t          port_data [NUM_PORTS],
    input  logic [NUM_PORTS-1:0]  port_valid_i,
    output logic [NUM_PORTS-1:0]  port_ready_o,
    output logic [NUM_PORTS-1:0]  port_commit_o,
    output logic                  ctrl_commit,
    input  logic                  ctrl_begin_irq,
    output logic                  ctrl_flush_begin,
    output logic                  ctrl_trap,
    output logic [4:0]            ctrl_trap_cause,
    output word                   ctrl_trap_value,
    output word                   ctrl_next_pc,
    input  logic                  flush_req,
    input  word                   flush_target,
    output logic                  flush_ack,
    output reg_addr               wr_addr,
    output word                   wr_data,
    output logic                  wr_en,
    output reg_mask               commit_mask,
    output logic [RETIRE_W-1:0]   retire_count,
    output insn_token             token_o,
    output logic                  dup_token_err
);

    localparam logic [RETIRE_W-1:0] RETIRE_INC = {{(RETIRE_W-1){1'b0}}, 1'b1};

    commit_state_t         state_q, state_d;
    insn_token             token_q, token_d;
    logic [RETIRE_W-1:0]   retire_q, retire_d;
    word                   next_pc_q, next_pc_d;
    logic                  trap_q, trap_d;
    logic [4:0]            cause_q, cause_d;
    word                   value_q, value_d;
    logic                  dup_q, dup_d;
    logic                  flush_ack_q, flush_ack_d;

    logic [NUM_PORTS-1:0]  accept_s;
    commit_data_t          used_s;
    logic                  dup_s;
    logic                  run_s;
    logic                  flush_done_s;
    logic                  accept_any_s;
    logic                  trap_acc_s;
    logic                  retire_acc_s;

    hsv_core_commit_select #(
        .NUM_PORTS (NUM_PORTS)
    ) u_select (
        .port_data_i  (port_data),
        .port_valid_i (port_valid_i),
        .token_i      (token_q),
        .enable_i     (run_s),
        .ready_o      (port_ready_o),
        .accept_o     (accept_s),
        .used_o       (used_s),
        .dup_o        (dup_s)
    );

    // State register; every flop returns to its reset value asynchronously.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q     <= RUN;
            token_q     <= '0;
            retire_q    <= '0;
            next_pc_q   <= RESET_PC;
            trap_q      <= 1'b0;
            cause_q     <= 5'd0;
            value_q     <= 32'h0000_0000;
            dup_q       <= 1'b0;
            flush_ack_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            token_q     <= token_d;
            retire_q    <= retire_d;
            next_pc_q   <= next_pc_d;
            trap_q      <= trap_d;
            cause_q     <= cause_d;
            value_q     <= value_d;
            dup_q       <= dup_d;
            flush_ack_q <= flush_ack_d;
        end
    end

    // Next-state logic; an accept racing flush_req still lands in FLUSH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (flush_req) begin
                    state_d = FLUSH;
                end else if (accept_any_s && ctrl_flush_begin) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (flush_req) begin
                    state_d = FLUSH;
                end else begin
                    state_d = DRAIN;
                end
            end
            FLUSH: begin
                if (flush_done_s) begin
                    state_d = RUN;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State-decoded controls.
    always_comb begin
        run_s        = (state_q == RUN) & ~ctrl_begin_irq;
        flush_done_s = (state_q == FLUSH) & flush_ack_q & ~flush_req;
    end

    // Accept qualification and combinational writeback toward regfile/scoreboard.
    always_comb begin
        accept_any_s  = |accept_s;
        trap_acc_s    = accept_any_s & used_s.trap;
        retire_acc_s  = accept_any_s & ~used_s.trap;
        port_commit_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_commit_o[i] = accept_s[i] & ~port_data[i].trap;
        end
        ctrl_commit      = |port_commit_o;
        wr_addr          = used_s.common.rd_addr;
        wr_data          = used_s.result;
        wr_en            = used_s.writeback & ~used_s.trap;
        commit_mask      = used_s.trap ? 32'h0000_0000 : used_s.rd_mask;
        ctrl_flush_begin = used_s.jump | used_s.trap;
    end

    // Register next values: flush restart, normal retire or trap capture.
    always_comb begin
        token_d     = token_q;
        retire_d    = retire_q;
        next_pc_d   = next_pc_q;
        cause_d     = cause_q;
        value_d     = value_q;
        trap_d      = trap_acc_s;
        dup_d       = dup_q | dup_s;
        flush_ack_d = flush_req;
        if (flush_done_s) begin
            token_d   = '0;
            next_pc_d = flush_target;
        end else if (retire_acc_s) begin
            token_d   = token_q + TOKEN_INC;
            retire_d  = retire_q + RETIRE_INC;
            next_pc_d = used_s.next_pc;
        end else begin
            token_d   = token_q;
        end
        if (trap_acc_s) begin
            cause_d = used_s.trap_cause;
            value_d = used_s.trap_value;
        end else begin
            cause_d = cause_q;
        end
    end

    assign ctrl_trap       = trap_q;
    assign ctrl_trap_cause = cause_q;
    assign ctrl_trap_value = value_q;
    assign ctrl_next_pc    = next_pc_q;
    assign flush_ack       = flush_ack_q;
    assign retire_count    = retire_q;
    assign token_o         = token_q;
    assign dup_token_err   = dup_q;

endmodule

// File: tb/tb_hsv_core_commit_multi.sv
// Scoreboard bench for hsv_core_commit_multi: expected post-commit state is
// queued when a record is driven and compared once the DUT registers it.
module tb_hsv_core_commit_multi;
    import hsv_core_pkg::*;

    localparam int  NP    = 5;
    localparam word RST_PC = 32'h0000_1000;

    typedef struct packed {
        insn_token   token;
        logic [63:0] retire;
        word         pc;
    } exp_t;

    logic          clk_core = 1'b0;
    logic          rst_core_n;
    commit_data_t  port_data [NP];
    logic [NP-1:0] port_valid_i, port_ready_o, port_commit_o;
    logic          ctrl_commit, ctrl_begin_irq, ctrl_flush_begin, ctrl_trap;
    logic [4:0]    ctrl_trap_cause;
    word           ctrl_trap_value, ctrl_next_pc, flush_target, wr_data;
    logic          flush_req, flush_ack, wr_en, dup_token_err;
    reg_addr       wr_addr;
    reg_mask       commit_mask;
    logic [63:0]   retire_count;
    insn_token     token_o;

    exp_t        sb [$];
    insn_token   m_token;
    logic [63:0] m_retire;
    word         m_pc;
    int          tests_run    = 0;
    int          tests_failed = 0;

    hsv_core_commit_multi #(
        .NUM_PORTS (NP),
        .RESET_PC  (RST_PC),
        .RETIRE_W  (64)
    ) dut (
        .clk_core         (clk_core),
        .rst_core_n       (rst_core_n),
        .port_data        (port_data),
        .port_valid_i     (port_valid_i),
        .port_ready_o     (port_ready_o),
        .port_commit_o    (port_commit_o),
        .ctrl_commit      (ctrl_commit),
        .ctrl_begin_irq   (ctrl_begin_irq),
        .ctrl_flush_begin (ctrl_flush_begin),
        .ctrl_trap        (ctrl_trap),
        .ctrl_trap_cause  (ctrl_trap_cause),
        .ctrl_trap_value  (ctrl_trap_value),
        .ctrl_next_pc     (ctrl_next_pc),
        .flush_req        (flush_req),
        .flush_target     (flush_target),
        .flush_ack        (flush_ack),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_en            (wr_en),
        .commit_mask      (commit_mask),
        .retire_count     (retire_count),
        .token_o          (token_o),
        .dup_token_err    (dup_token_err)
    );

    always #5 clk_core = ~clk_core;

    function automatic commit_data_t mk(input insn_token tok, input int rd, input word res,
                                        input word npc, input logic jmp, input logic trp,
                                        input logic [4:0] cause, input word val);
        commit_data_t r;
        r = '0;
        r.common.token  = tok;
        r.common.rd_addr = reg_addr'(rd);
        r.result        = res;
        r.next_pc       = npc;
        r.rd_mask       = 32'h0000_0001 << rd;
        r.writeback     = 1'b1;
        r.jump          = jmp;
        r.trap          = trp;
        r.trap_cause    = cause;
        r.trap_value    = val;
        return r;
    endfunction

    task automatic clear_ports();
        for (int i = 0; i < NP; i++) begin
            port_data[i] = '0;
            port_data[i].common.token = 4'hF;
        end
        port_valid_i = 5'b00000;
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    // Drive one non-trap record on port p and check the retire one edge later.
    task automatic commit_one(input int p, input commit_data_t r);
        exp_t e;
        clear_ports();
        port_data[p] = r;
        port_valid_i[p] = 1'b1;
        #1;
        tests_run++;
        if (port_commit_o !== (5'b00001 << p) || ctrl_commit !== 1'b1 || wr_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL commit_comb port=%0d: commit=%b ctrl_commit=%b wr_en=%b, want commit=%b 1 1",
                     p, port_commit_o, ctrl_commit, wr_en, 5'b00001 << p);
        end
        tests_run++;
        if (wr_addr !== r.common.rd_addr || wr_data !== r.result || commit_mask !== r.rd_mask ||
            ctrl_flush_begin !== r.jump) begin
            tests_failed++;
            $display("FAIL commit_wb: addr=%0d data=%h mask=%h fb=%b, want %0d %h %h %b",
                     wr_addr, wr_data, commit_mask, ctrl_flush_begin,
                     r.common.rd_addr, r.result, r.rd_mask, r.jump);
        end
        m_token  = m_token + 4'd1;
        m_retire = m_retire + 64'd1;
        m_pc     = r.next_pc;
        sb.push_back('{token: m_token, retire: m_retire, pc: m_pc});
        tick();
        clear_ports();
        e = sb.pop_front();
        tests_run++;
        if (token_o !== e.token || retire_count !== e.retire || ctrl_next_pc !== e.pc) begin
            tests_failed++;
            $display("FAIL commit_regs: token=%0d retire=%0d pc=%h, want %0d %0d %h",
                     token_o, retire_count, ctrl_next_pc, e.token, e.retire, e.pc);
        end
    endtask

    // Hold flush_req two cycles then drop it; ports stay blocked until RUN.
    task automatic do_flush(input word target);
        flush_req    = 1'b1;
        flush_target = target;
        port_data[0].common.token = m_token;
        port_valid_i[0] = 1'b1;
        #1;
        tests_run++;
        if (port_ready_o !== 5'b00000) begin
            tests_failed++;
            $display("FAIL flush_ready_drain: ready=%b, want 00000", port_ready_o);
        end
        tick();
        tests_run++;
        if (flush_ack !== 1'b1 || port_ready_o !== 5'b00000) begin
            tests_failed++;
            $display("FAIL flush_ack_rise: ack=%b ready=%b, want 1 00000", flush_ack, port_ready_o);
        end
        tick();
        flush_req = 1'b0;
        #1;
        tests_run++;
        if (port_ready_o !== 5'b00000) begin
            tests_failed++;
            $display("FAIL flush_ready_flush: ready=%b, want 00000", port_ready_o);
        end
        tick();
        m_token = 4'd0;
        m_pc    = target;
        clear_ports();
        port_data[0].common.token = 4'd0;
        #1;
        tests_run++;
        if (token_o !== 4'd0 || ctrl_next_pc !== target || port_ready_o[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_exit: token=%0d pc=%h ready0=%b, want 0 %h 1",
                     token_o, ctrl_next_pc, port_ready_o[0], target);
        end
        clear_ports();
    endtask

    task automatic test_reset();
        rst_core_n = 1'b0;
        ctrl_begin_irq = 1'b0;
        flush_req = 1'b0;
        flush_target = 32'h0000_0000;
        clear_ports();
        m_token = 4'd0; m_retire = 64'd0; m_pc = RST_PC;
        repeat (3) @(posedge clk_core);
        #1;
        tests_run++;
        if (token_o !== 4'd0 || retire_count !== 64'd0 || ctrl_next_pc !== RST_PC) begin
            tests_failed++;
            $display("FAIL reset_counters: token=%0d retire=%0d pc=%h, want 0 0 %h",
                     token_o, retire_count, ctrl_next_pc, RST_PC);
        end
        tests_run++;
        if (ctrl_trap !== 1'b0 || ctrl_trap_cause !== 5'd0 || ctrl_trap_value !== 32'h0 ||
            dup_token_err !== 1'b0 || flush_ack !== 1'b1 || ctrl_commit !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: trap=%b cause=%0d val=%h dup=%b ack=%b commit=%b, want 0 0 0 0 1 0",
                     ctrl_trap, ctrl_trap_cause, ctrl_trap_value, dup_token_err, flush_ack, ctrl_commit);
        end
        @(negedge clk_core);
        rst_core_n = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        commit_one(0, mk(4'd0, 1, 32'hA000_0001, 32'h0000_1004, 1'b0, 1'b0, 5'd0, 32'h0));
        commit_one(3, mk(4'd1, 2, 32'hA000_0002, 32'h0000_1008, 1'b0, 1'b0, 5'd0, 32'h0));
        commit_one(1, mk(4'd2, 7, 32'hA000_0003, 32'h0000_100C, 1'b0, 1'b0, 5'd0, 32'h0));
        tests_run++;
        if (token_o !== 4'd3 || retire_count !== 64'd3) begin
            tests_failed++;
            $display("FAIL in_order_final: token=%0d retire=%0d, want 3 3", token_o, retire_count);
        end
    endtask

    task automatic test_trap();
        exp_t e;
        clear_ports();
        port_data[2] = mk(m_token, 5, 32'h1111_1111, 32'h0000_2000, 1'b0, 1'b1, 5'd2, 32'h0000_DEAD);
        port_valid_i[2] = 1'b1;
        #1;
        tests_run++;
        if (wr_en !== 1'b0 || commit_mask !== 32'h0 || port_commit_o !== 5'b00000 ||
            ctrl_commit !== 1'b0 || ctrl_flush_begin !== 1'b1) begin
            tests_failed++;
            $display("FAIL trap_comb: wr_en=%b mask=%h commit=%b cc=%b fb=%b, want 0 0 00000 0 1",
                     wr_en, commit_mask, port_commit_o, ctrl_commit, ctrl_flush_begin);
        end
        sb.push_back('{token: m_token, retire: m_retire, pc: m_pc});
        tick();
        clear_ports();
        e = sb.pop_front();
        tests_run++;
        if (ctrl_trap !== 1'b1 || ctrl_trap_cause !== 5'd2 || ctrl_trap_value !== 32'h0000_DEAD) begin
            tests_failed++;
            $display("FAIL trap_regs: trap=%b cause=%0d val=%h, want 1 2 0000dead",
                     ctrl_trap, ctrl_trap_cause, ctrl_trap_value);
        end
        tests_run++;
        if (token_o !== e.token || retire_count !== e.retire || ctrl_next_pc !== e.pc) begin
            tests_failed++;
            $display("FAIL trap_hold: token=%0d retire=%0d pc=%h, want %0d %0d %h",
                     token_o, retire_count, ctrl_next_pc, e.token, e.retire, e.pc);
        end
        port_data[0] = mk(m_token, 3, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        port_valid_i[0] = 1'b1;
        #1;
        tests_run++;
        if (port_ready_o !== 5'b00000 || ctrl_commit !== 1'b0) begin
            tests_failed++;
            $display("FAIL trap_drain_block: ready=%b commit=%b, want 00000 0", port_ready_o, ctrl_commit);
        end
        tick();
        tests_run++;
        if (ctrl_trap !== 1'b0 || ctrl_trap_cause !== 5'd2 || token_o !== m_token) begin
            tests_failed++;
            $display("FAIL trap_clear: trap=%b cause=%0d token=%0d, want 0 2 %0d",
                     ctrl_trap, ctrl_trap_cause, token_o, m_token);
        end
        clear_ports();
        do_flush(32'h0000_0300);
    endtask

    task automatic test_jump_flush();
        commit_one(4, mk(m_token, 9, 32'h0000_0042, 32'h0000_0100, 1'b1, 1'b0, 5'd0, 32'h0));
        do_flush(32'h0000_0200);
    endtask

    task automatic test_irq();
        clear_ports();
        ctrl_begin_irq = 1'b1;
        port_data[1] = mk(m_token, 4, 32'h5555_5555, 32'h0000_0400, 1'b0, 1'b0, 5'd0, 32'h0);
        port_valid_i[1] = 1'b1;
        #1;
        tests_run++;
        if (port_ready_o !== 5'b00000 || ctrl_commit !== 1'b0 || wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_block: ready=%b commit=%b wr_en=%b, want 00000 0 0",
                     port_ready_o, ctrl_commit, wr_en);
        end
        tick();
        tests_run++;
        if (token_o !== m_token || retire_count !== m_retire || ctrl_next_pc !== m_pc) begin
            tests_failed++;
            $display("FAIL irq_hold: token=%0d retire=%0d pc=%h, want %0d %0d %h",
                     token_o, retire_count, ctrl_next_pc, m_token, m_retire, m_pc);
        end
        ctrl_begin_irq = 1'b0;
        clear_ports();
    endtask

    task automatic test_dup();
        commit_data_t r;
        r = mk(m_token, 6, 32'h0000_0066, 32'h0000_0500, 1'b0, 1'b0, 5'd0, 32'h0);
        clear_ports();
        port_data[0] = r;
        port_data[3] = r;
        port_valid_i = 5'b01001;
        m_token = m_token + 4'd1; m_retire = m_retire + 64'd1; m_pc = r.next_pc;
        tick();
        clear_ports();
        tests_run++;
        if (dup_token_err !== 1'b1 || token_o !== m_token) begin
            tests_failed++;
            $display("FAIL dup_set: dup=%b token=%0d, want 1 %0d", dup_token_err, token_o, m_token);
        end
        commit_one(2, mk(m_token, 8, 32'h0000_0077, 32'h0000_0504, 1'b0, 1'b0, 5'd0, 32'h0));
        tests_run++;
        if (dup_token_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL dup_sticky: dup=%b, want 1", dup_token_err);
        end
    endtask

    task automatic test_back_to_back();
        insn_token start;
        start = m_token;
        for (int n = 0; n < 17; n++) begin
            commit_one(n % NP, mk(m_token, (n % 31) + 1, 32'hB000_0000 + n,
                                  32'h0000_6000 + 4 * n, 1'b0, 1'b0, 5'd0, 32'h0));
        end
        tests_run++;
        if (token_o !== start + 4'd1 || dup_token_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL token_wrap: token=%0d dup=%b, want %0d 1", token_o, dup_token_err, start + 4'd1);
        end
    endtask

    task automatic test_reset_mid_drain();
        commit_one(1, mk(m_token, 2, 32'h0, 32'h0000_0700, 1'b1, 1'b0, 5'd0, 32'h0));
        #2;
        rst_core_n = 1'b0;
        port_data[0].common.token = 4'd0;
        #1;
        tests_run++;
        if (token_o !== 4'd0 || retire_count !== 64'd0 || ctrl_next_pc !== RST_PC ||
            dup_token_err !== 1'b0 || flush_ack !== 1'b1 || ctrl_trap !== 1'b0 ||
            ctrl_trap_cause !== 5'd0 || ctrl_trap_value !== 32'h0 || port_ready_o[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset: token=%0d retire=%0d pc=%h dup=%b ack=%b trap=%b cause=%0d val=%h ready0=%b",
                     token_o, retire_count, ctrl_next_pc, dup_token_err, flush_ack,
                     ctrl_trap, ctrl_trap_cause, ctrl_trap_value, port_ready_o[0]);
        end
        clear_ports();
        @(negedge clk_core);
        rst_core_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_trap();
        test_jump_flush();
        test_irq();
        test_dup();
        test_back_to_back();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
